vga_timing_multimode: RTL and testbench

Parametrised VGA raster timing generator, the successor to the fixed 1024x768 timing constants. It holds two complete raster descriptions (mode A and mode B) and switches between them only at a frame boundary. It also provides start-of-frame and start-of-line strobes and a frame counter. It sits between the 65 MHz clock domain root and the drawing pipeline; all downstream draw stages consume its counters and sync/blank signals.

---
 rtl/vga_timing_multimode.sv | 164 ++++++++++++++++
 tb/tb_vga_timing_multimode.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_multimode.sv
// vga_timing_multimode: two-mode VGA raster generator.
// Holds two raster descriptions and only swaps between them on the frame wrap,
// so downstream draw stages always see a complete frame in a single mode.
// Every output is registered and describes the same (hcount, vcount) pixel.
module vga_timing_multimode #(
  parameter int   CNT_W            = 11,
  parameter int   FRAME_W          = 8,
  parameter int   A_H_TOTAL        = 1344,
  parameter int   A_H_BLANK        = 1024,
  parameter int   A_H_SYNC_START   = 1048,
  parameter int   A_H_SYNC_END     = 1184,
  parameter int   A_V_TOTAL        = 806,
  parameter int   A_V_BLANK        = 768,
  parameter int   A_V_SYNC_START   = 771,
  parameter int   A_V_SYNC_END     = 777,
  parameter int   B_H_TOTAL        = 1056,
  parameter int   B_H_BLANK        = 800,
  parameter int   B_H_SYNC_START   = 840,
  parameter int   B_H_SYNC_END     = 968,
  parameter int   B_V_TOTAL        = 628,
  parameter int   B_V_BLANK        = 600,
  parameter int   B_V_SYNC_START   = 601,
  parameter int   B_V_SYNC_END     = 605,
  parameter logic SYNC_POL         = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mode_sel,
  output logic [CNT_W-1:0]   hcount,
  output logic [CNT_W-1:0]   vcount,
  output logic               hblnk,
  output logic               vblnk,
  output logic               hsync,
  output logic               vsync,
  output logic               line_start,
  output logic               frame_start,
  output logic               mode_active,
  output logic [FRAME_W-1:0] frame_cnt
);

  // Timing tables indexed by mode (0 = A, 1 = B).
  localparam int H_TOTAL [2] = '{A_H_TOTAL,      B_H_TOTAL};
  localparam int H_BLANK [2] = '{A_H_BLANK,      B_H_BLANK};
  localparam int H_SS    [2] = '{A_H_SYNC_START, B_H_SYNC_START};
  localparam int H_SE    [2] = '{A_H_SYNC_END,   B_H_SYNC_END};
  localparam int V_TOTAL [2] = '{A_V_TOTAL,      B_V_TOTAL};
  localparam int V_BLANK [2] = '{A_V_BLANK,      B_V_BLANK};
  localparam int V_SS    [2] = '{A_V_SYNC_START, B_V_SYNC_START};
  localparam int V_SE    [2] = '{A_V_SYNC_END,   B_V_SYNC_END};

  // Comparisons are done one bit wider than the counters, since a total may
  // equal 2^CNT_W exactly.
  typedef logic [CNT_W:0] cmp_t;

  typedef struct packed {
    cmp_t ht;
    cmp_t hb;
    cmp_t hss;
    cmp_t hse;
    cmp_t vt;
    cmp_t vb;
    cmp_t vss;
    cmp_t vse;
  } timing_t;

  // Reject raster descriptions that cannot be generated.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_check
      if (H_TOTAL[gi] > (1 << CNT_W) || V_TOTAL[gi] > (1 << CNT_W) ||
          H_TOTAL[gi] < 1 || V_TOTAL[gi] < 1) begin : g_bad_total
        $fatal(1, "vga_timing_multimode: mode %0d total does not fit CNT_W", gi);
      end
      if (!(H_BLANK[gi] <= H_SS[gi] && H_SS[gi] < H_SE[gi] && H_SE[gi] <= H_TOTAL[gi]))
      begin : g_bad_h
        $fatal(1, "vga_timing_multimode: mode %0d horizontal timing out of order", gi);
      end
      if (!(V_BLANK[gi] <= V_SS[gi] && V_SS[gi] < V_SE[gi] && V_SE[gi] <= V_TOTAL[gi]))
      begin : g_bad_v
        $fatal(1, "vga_timing_multimode: mode %0d vertical timing out of order", gi);
      end
    end
  endgenerate

  function automatic timing_t sel_timing(input logic m);
    timing_t t;
    t.ht  = cmp_t'(H_TOTAL[m]);
    t.hb  = cmp_t'(H_BLANK[m]);
    t.hss = cmp_t'(H_SS[m]);
    t.hse = cmp_t'(H_SE[m]);
    t.vt  = cmp_t'(V_TOTAL[m]);
    t.vb  = cmp_t'(V_BLANK[m]);
    t.vss = cmp_t'(V_SS[m]);
    t.vse = cmp_t'(V_SE[m]);
    return t;
  endfunction

  timing_t            cur_t;
  timing_t            nxt_t;
  logic               h_last;
  logic               v_last;
  logic               frame_wrap;
  logic               mode_next;
  logic [CNT_W-1:0]   h_next;
  logic [CNT_W-1:0]   v_next;
  cmp_t               h_next_x;
  cmp_t               v_next_x;
  logic               hblnk_next;
  logic               vblnk_next;
  logic               hsync_next;
  logic               vsync_next;

  // Next raster position, next mode, and the flags for that next position,
  // evaluated with the timing of the mode that pixel belongs to.
  always_comb begin
    cur_t      = sel_timing(mode_active);
    h_last     = ({1'b0, hcount} == cur_t.ht - 1'b1);
    v_last     = ({1'b0, vcount} == cur_t.vt - 1'b1);
    frame_wrap = h_last && v_last;
    mode_next  = frame_wrap ? mode_sel : mode_active;
    h_next     = h_last ? '0 : hcount + 1'b1;
    v_next     = vcount;
    if (h_last) begin
      v_next = v_last ? '0 : vcount + 1'b1;
    end
    nxt_t      = sel_timing(mode_next);
    h_next_x   = {1'b0, h_next};
    v_next_x   = {1'b0, v_next};
    hblnk_next = (h_next_x >= nxt_t.hb);
    vblnk_next = (v_next_x >= nxt_t.vb);
    hsync_next = (h_next_x >= nxt_t.hss && h_next_x < nxt_t.hse) ? SYNC_POL : ~SYNC_POL;
    vsync_next = (v_next_x >= nxt_t.vss && v_next_x < nxt_t.vse) ? SYNC_POL : ~SYNC_POL;
  end

  // Register the whole pixel description together so nothing skews.
  always_ff @(posedge clk) begin
    if (rst) begin
      hcount      <= '0;
      vcount      <= '0;
      hblnk       <= 1'b0;
      vblnk       <= 1'b0;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      mode_active <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      hcount      <= h_next;
      vcount      <= v_next;
      hblnk       <= hblnk_next;
      vblnk       <= vblnk_next;
      hsync       <= hsync_next;
      vsync       <= vsync_next;
      line_start  <= h_last;
      frame_start <= frame_wrap;
      mode_active <= mode_next;
      if (frame_wrap) begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_multimode.sv
// tb_vga_timing_multimode: random and directed stimulus for the two-mode
// raster generator, checked every cycle against a linear-pixel-index model,
// with a few hand-computed expectations for periods and counters.
module tb_vga_timing_multimode;

  localparam int   CNT_W   = 5;
  localparam int   FRAME_W = 2;
  localparam logic POL     = 1'b0;

  // Mode A: 20x12 raster (240 cycles/frame); mode B: 8x4 raster (32 cycles/frame).
  localparam int MHT  [2] = '{20, 8};
  localparam int MHB  [2] = '{14, 6};
  localparam int MHSS [2] = '{15, 6};
  localparam int MHSE [2] = '{18, 7};
  localparam int MVT  [2] = '{12, 4};
  localparam int MVB  [2] = '{9, 3};
  localparam int MVSS [2] = '{10, 3};
  localparam int MVSE [2] = '{11, 4};

  logic               clk;
  logic               rst;
  logic               mode_sel;
  logic [CNT_W-1:0]   hcount;
  logic [CNT_W-1:0]   vcount;
  logic               hblnk;
  logic               vblnk;
  logic               hsync;
  logic               vsync;
  logic               line_start;
  logic               frame_start;
  logic               mode_active;
  logic [FRAME_W-1:0] frame_cnt;

  vga_timing_multimode #(
    .CNT_W(CNT_W), .FRAME_W(FRAME_W),
    .A_H_TOTAL(20), .A_H_BLANK(14), .A_H_SYNC_START(15), .A_H_SYNC_END(18),
    .A_V_TOTAL(12), .A_V_BLANK(9),  .A_V_SYNC_START(10), .A_V_SYNC_END(11),
    .B_H_TOTAL(8),  .B_H_BLANK(6),  .B_H_SYNC_START(6),  .B_H_SYNC_END(7),
    .B_V_TOTAL(4),  .B_V_BLANK(3),  .B_V_SYNC_START(3),  .B_V_SYNC_END(4),
    .SYNC_POL(POL)
  ) dut (
    .clk(clk), .rst(rst), .mode_sel(mode_sel),
    .hcount(hcount), .vcount(vcount),
    .hblnk(hblnk), .vblnk(vblnk), .hsync(hsync), .vsync(vsync),
    .line_start(line_start), .frame_start(frame_start),
    .mode_active(mode_active), .frame_cnt(frame_cnt)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: pixel index within the current frame, mode, frame count.
  int m_t     = 0;
  int m_mode  = 0;
  int m_fcnt  = 0;
  bit m_rst   = 0;
  bit m_valid = 0;

  int e_h, e_v, e_ht;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at time %0t", name, act, exp, $time);
    end
  endtask

  // Model advance: one pixel per cycle, frame wrap samples mode_sel.
  always @(posedge clk) begin
    if (rst) begin
      m_t     = 0;
      m_mode  = 0;
      m_fcnt  = 0;
      m_rst   = 1;
      m_valid = 1;
    end else if (m_valid) begin
      if (m_t == MHT[m_mode] * MVT[m_mode] - 1) begin
        m_t    = 0;
        m_mode = int'(mode_sel);
        m_fcnt = (m_fcnt + 1) % (1 << FRAME_W);
      end else begin
        m_t = m_t + 1;
      end
      m_rst = 0;
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (m_valid) begin
      e_ht = MHT[m_mode];
      e_h  = m_t % e_ht;
      e_v  = m_t / e_ht;
      chk("hcount", hcount, e_h);
      chk("vcount", vcount, e_v);
      chk("hblnk", hblnk, m_rst ? 0 : (e_h >= MHB[m_mode]));
      chk("vblnk", vblnk, m_rst ? 0 : (e_v >= MVB[m_mode]));
      chk("hsync", hsync, (!m_rst && e_h >= MHSS[m_mode] && e_h < MHSE[m_mode]) ? POL : !POL);
      chk("vsync", vsync, (!m_rst && e_v >= MVSS[m_mode] && e_v < MVSE[m_mode]) ? POL : !POL);
      chk("line_start", line_start, !m_rst && e_h == 0);
      chk("frame_start", frame_start, !m_rst && m_t == 0);
      chk("mode_active", mode_active, m_mode);
      chk("frame_cnt", frame_cnt, m_fcnt);
    end
  end

  // Count negedges until frame_start is seen, bounded by limit.
  task automatic wait_fs(input int limit, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame_start !== 1'b1 && n < limit);
    chk("frame_start_seen", frame_start, 1);
  endtask

  int n;
  int k;
  int exp_fc [4] = '{3, 0, 1, 2};

  initial begin
    rst      = 1'b1;
    mode_sel = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_hcount", hcount, 0);
    chk("rst_mode_active", mode_active, 0);
    chk("rst_hsync", hsync, 1);
    chk("rst_frame_cnt", frame_cnt, 0);
    $display("reset held 5 cycles: hcount=%0d mode_active=%0d", hcount, mode_active);
    rst      = 1'b0;
    mode_sel = 1'b0;

    // First frame in mode A: 20*12 = 240 cycles to the first frame_start.
    wait_fs(300, n);
    chk("first_frame_delay", n, 240);
    chk("first_frame_cnt", frame_cnt, 1);
    $display("first frame_start after %0d cycles, frame_cnt=%0d", n, frame_cnt);

    // Request mode B mid-frame, glitch the request, then hold it.
    repeat (100) @(negedge clk);
    mode_sel = 1'b1;
    repeat (20) @(negedge clk);
    mode_sel = 1'b0;
    @(negedge clk);
    mode_sel = 1'b1;
    chk("mode_hold_midframe", mode_active, 0);
    wait_fs(200, n);
    chk("switch_remaining", n, 119);
    chk("switch_mode_active", mode_active, 1);
    chk("switch_frame_cnt", frame_cnt, 2);
    $display("mode switch at frame_start: mode_active=%0d frame_cnt=%0d", mode_active, frame_cnt);

    // Mode B frames: 8*4 = 32 cycles apart, frame_cnt wraps modulo 4.
    for (int i = 0; i < 4; i++) begin
      wait_fs(100, n);
      chk("b_frame_period", n, 32);
      chk("b_frame_cnt", frame_cnt, exp_fc[i]);
      $display("mode B frame_start %0d: period=%0d frame_cnt=%0d", i, n, frame_cnt);
    end

    // Mid-frame reset at (5,2) in mode B with mode_sel still 1.
    k = 0;
    while (!(hcount == 5 && vcount == 2) && k < 64) begin
      @(negedge clk);
      k++;
    end
    chk("reach_5_2", (hcount == 5 && vcount == 2), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_hcount", hcount, 0);
    chk("mid_rst_vcount", vcount, 0);
    chk("mid_rst_mode", mode_active, 0);
    chk("mid_rst_frame_cnt", frame_cnt, 0);
    chk("mid_rst_vsync", vsync, 1);
    chk("mid_rst_frame_start", frame_start, 0);
    $display("mid-frame reset: hcount=%0d vcount=%0d mode_active=%0d frame_cnt=%0d",
             hcount, vcount, mode_active, frame_cnt);
    rst = 1'b0;

    // Random phase: mode_sel toggles at arbitrary times, occasional resets.
    for (int i = 0; i < 8000; i++) begin
      @(negedge clk);
      if ($urandom_range(15, 0) == 0) mode_sel = ~mode_sel;
      rst = ($urandom_range(1499, 0) == 0);
      if (rst) $display("random reset at cycle %0d", i);
    end
    rst = 1'b0;
    repeat (10) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
